count_seq_checker: RTL and testbench

COUNT_SEQ_CHECKER -- requirements
Module: count_seq_checker

---
 rtl/count_seq_checker.sv | 145 ++++++++++++++
 tb/tb_count_seq_checker.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/count_seq_checker.sv
`default_nettype none
// ============================================================================
// Module      : count_seq_checker
// Description : Monitors a free-running 3-bit counter and its complementary
//               outputs. It locks after LOCK_CNT consecutive +1 (mod 8)
//               steps and then flags sequence breaks, wraps and complement
//               mismatches. It also keeps a saturating error count.
//               Optional feature macro: CSC_COMPL_CHECK_EN (compiles in the
//               q/qn complement check; when undefined, qn is ignored).
// Revision    : 1.0 - initial release
// ============================================================================
module count_seq_checker #(
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       q,
    input  logic [2:0]       qn,
    output logic             locked,
    output logic             err_pulse,
    output logic             compl_err,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       onehot,
    output logic             wrap_pulse
);

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_SYNC   = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    localparam logic [3:0]       c_lock_cnt = 4'(LOCK_CNT);
    localparam logic [ERR_W-1:0] c_err_max  = {ERR_W{1'b1}};

    state_t             state_q, state_d;
    logic [3:0]         good_cnt_q, good_cnt_d;
    logic [2:0]         prev_q_q;
    logic               locked_q, err_pulse_q, compl_err_q, wrap_pulse_q;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic [7:0]         onehot_q, onehot_d;
    logic               err_pulse_d, wrap_pulse_d;

    logic [2:0]         w_exp_q;
    logic               w_inc_ok;
    logic               w_compl_bad;
    logic               w_err_event;

    assign w_exp_q  = prev_q_q + 3'd1;
    assign w_inc_ok = (q == w_exp_q);

`ifdef CSC_COMPL_CHECK_EN
    assign w_compl_bad = (q != ~qn);
`else
    // qn is intentionally ignored in this build
    logic w_unused_qn;
    assign w_unused_qn = ^qn;
    assign w_compl_bad = 1'b0;
`endif

    // Next-state and next-output computation for the tracking FSM
    always_comb begin
        state_d      = state_q;
        good_cnt_d   = good_cnt_q;
        err_pulse_d  = 1'b0;
        wrap_pulse_d = 1'b0;
        case (state_q)
            S_HUNT: begin
                // First sample only seeds prev_q; nothing to compare yet
                state_d    = S_SYNC;
                good_cnt_d = 4'd0;
            end
            S_SYNC: begin
                if (w_inc_ok) begin
                    good_cnt_d = good_cnt_q + 4'd1;
                    if (good_cnt_q + 4'd1 == c_lock_cnt) begin
                        state_d = S_LOCKED;
                    end
                end else begin
                    // Not yet trusted: restart the run silently
                    good_cnt_d = 4'd0;
                end
            end
            S_LOCKED: begin
                wrap_pulse_d = (prev_q_q == 3'd7) && (q == 3'd0);
                if (!w_inc_ok || w_compl_bad) begin
                    err_pulse_d = 1'b1;
                    state_d     = S_SYNC;
                    good_cnt_d  = 4'd0;
                end
            end
            default: begin
                state_d    = S_HUNT;
                good_cnt_d = 4'd0;
            end
        endcase
    end

    // A break and a complement error in one sample count as a single event
    assign w_err_event = err_pulse_d | w_compl_bad;

    // Saturating error counter and one-hot decode of the current sample
    always_comb begin
        err_count_d = err_count_q;
        if (w_err_event && (err_count_q != c_err_max)) begin
            err_count_d = err_count_q + 1'b1;
        end
        onehot_d = 8'(8'h01 << q);
    end

    // State and registered outputs; reset overrides every event
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_HUNT;
            good_cnt_q   <= 4'd0;
            prev_q_q     <= 3'd0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            compl_err_q  <= 1'b0;
            wrap_pulse_q <= 1'b0;
            err_count_q  <= '0;
            onehot_q     <= 8'h01;
        end else begin
            state_q      <= state_d;
            good_cnt_q   <= good_cnt_d;
            prev_q_q     <= q;
            locked_q     <= (state_d == S_LOCKED);
            err_pulse_q  <= err_pulse_d;
            compl_err_q  <= w_compl_bad;
            wrap_pulse_q <= wrap_pulse_d;
            err_count_q  <= err_count_d;
            onehot_q     <= onehot_d;
        end
    end

    assign locked     = locked_q;
    assign err_pulse  = err_pulse_q;
    assign compl_err  = compl_err_q;
    assign err_count  = err_count_q;
    assign onehot     = onehot_q;
    assign wrap_pulse = wrap_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_count_seq_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_seq_checker
// Description : Directed self-checking bench for count_seq_checker
//               (LOCK_CNT = 4, ERR_W = 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_seq_checker;

`ifdef CSC_COMPL_CHECK_EN
    localparam bit COMPL_ON = 1'b1;
`else
    localparam bit COMPL_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] q;
    logic [2:0] qn;
    logic       locked, err_pulse, compl_err, wrap_pulse;
    logic [1:0] err_count;
    logic [7:0] onehot;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    count_seq_checker #(.LOCK_CNT(4), .ERR_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .q          (q),
        .qn         (qn),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .compl_err  (compl_err),
        .err_count  (err_count),
        .onehot     (onehot),
        .wrap_pulse (wrap_pulse)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Apply one sample and settle just after the capturing edge
    task automatic drive(input logic [2:0] v, input logic [2:0] vn);
        q  = v;
        qn = vn;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [2:0] v);
        drive(v, ~v);
    endtask

    initial begin
        logic [2:0] prev;
        logic [2:0] v;
        int         exp_err;

        // Reset for two cycles
        rst = 1'b1;
        step(3'd5);
        step(3'd5);
        check_eq("rst_locked", locked, 0);
        check_eq("rst_errcnt", err_count, 0);
        check_eq("rst_onehot", onehot, 8'h01);
        check_eq("rst_errp",   err_pulse, 0);
        check_eq("rst_compl",  compl_err, 0);
        check_eq("rst_wrap",   wrap_pulse, 0);
        rst = 1'b0;

        // Lock on 0,1,2,3,4
        step(3'd0);
        check_eq("hunt_locked", locked, 0);
        step(3'd1); step(3'd2); step(3'd3);
        check_eq("pre_lock", locked, 0);
        step(3'd4);
        check_eq("lock_locked", locked, 1);
        check_eq("lock_errcnt", err_count, 0);
        check_eq("lock_onehot", onehot, 8'h10);

        // Wrap 7 -> 0 while locked
        step(3'd5); step(3'd6); step(3'd7);
        check_eq("wrap_before", wrap_pulse, 0);
        step(3'd0);
        check_eq("wrap_pulse", wrap_pulse, 1);
        check_eq("wrap_locked", locked, 1);
        step(3'd1);
        check_eq("wrap_after", wrap_pulse, 0);
        check_eq("wrap_locked2", locked, 1);

        // Sequence break 3 -> 5
        step(3'd2); step(3'd3); step(3'd5);
        check_eq("brk_errp",   err_pulse, 1);
        check_eq("brk_errcnt", err_count, 1);
        check_eq("brk_locked", locked, 0);
        step(3'd6);
        check_eq("brk_errp_once", err_pulse, 0);
        step(3'd7); step(3'd0);
        check_eq("relock_pre", locked, 0);
        check_eq("relock_nowrap", wrap_pulse, 0);
        step(3'd1);
        check_eq("relock", locked, 1);

        // Second break to reach err_count = 2, then relock
        step(3'd4);
        check_eq("brk2_errcnt", err_count, 2);
        step(3'd5); step(3'd6); step(3'd7); step(3'd0);
        check_eq("relock2", locked, 1);
        check_eq("relock2_nowrap", wrap_pulse, 0);

        // Reset mid-lock
        rst = 1'b1;
        step(3'd3);
        rst = 1'b0;
        check_eq("midrst_locked", locked, 0);
        check_eq("midrst_errcnt", err_count, 0);
        check_eq("midrst_onehot", onehot, 8'h01);

        // Post-reset HUNT, then a SYNC mismatch that must not count
        step(3'd4);
        check_eq("hunt2_locked", locked, 0);
        step(3'd2);
        check_eq("sync_noerrp", err_pulse, 0);
        check_eq("sync_noerrcnt", err_count, 0);
        step(3'd3); step(3'd4); step(3'd5); step(3'd6);
        check_eq("lock3", locked, 1);
        step(3'd7); step(3'd0); step(3'd1); step(3'd2);

        // Complement error on q = 3, qn = 3'b101
        drive(3'd3, 3'b101);
        check_eq("compl_err",    compl_err, COMPL_ON ? 1 : 0);
        check_eq("compl_errp",   err_pulse, COMPL_ON ? 1 : 0);
        check_eq("compl_errcnt", err_count, COMPL_ON ? 1 : 0);
        check_eq("compl_locked", locked,    COMPL_ON ? 0 : 1);
        check_eq("compl_onehot", onehot, 8'h08);
        exp_err = COMPL_ON ? 1 : 0;
        step(3'd4);
        check_eq("compl_once", compl_err, 0);
        step(3'd5); step(3'd6); step(3'd7);
        check_eq("lock4", locked, 1);

        // Saturation: five breaks from LOCKED, relocking between each
        prev = 3'd7;
        for (int k = 0; k < 5; k++) begin
            v = prev + 3'd2;
            step(v);
            exp_err = (exp_err == 3) ? 3 : exp_err + 1;
            check_eq("sat_errp",   err_pulse, 1);
            check_eq("sat_errcnt", err_count, exp_err);
            prev = v;
            for (int j = 0; j < 4; j++) begin
                prev = prev + 3'd1;
                step(prev);
            end
            check_eq("sat_relock", locked, 1);
        end
        check_eq("sat_hold", err_count, 3);
        step(prev + 3'd1);
        check_eq("sat_final_errp", err_pulse, 0);
        check_eq("sat_final_cnt",  err_count, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
